// File: rtl/fetch_unit.sv
// fetch_unit: IDLE -> REQ -> LOAD instruction fetch with in-IDLE PC redirect.
// Optional macro FETCH_TIMEOUT_EN adds a REQ-state timeout that aborts via fetch_err.
module fetch_unit #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_req,
    input  logic        pc_load,
    input  logic [15:0] pc_target,
    input  logic        mem_resp,
    input  logic [15:0] mem_rdata,
    output logic        mem_read,
    output logic [15:0] mem_address,
    output logic [15:0] pc_out,
    output logic        ir_load,
    output logic [15:0] ir_data,
    output logic        fetch_done,
    output logic        fetch_err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam logic [15:0] RESET_PC_ALIGNED = {RESET_PC[15:1], 1'b0};

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pc_q;
    logic [15:0] ir_q;
    logic        tmo_hit;
    logic        unused_tgt_lsb;

    assign unused_tgt_lsb = pc_target[0];

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       err_q;

    assign tmo_hit = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

    // Counter restarts on every IDLE->REQ entry; mem_resp cycles do not count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= 8'd0;
        end else if (state == IDLE && state_nxt == REQ) begin
            tmo_cnt <= 8'd0;
        end else if (state == REQ && !mem_resp) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state == REQ) && !mem_resp && tmo_hit;
        end
    end

    assign fetch_err = err_q;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign tmo_hit   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // pc_load beats fetch_req in IDLE; a mem_resp in the timeout cycle still completes.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!pc_load && fetch_req) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_resp) begin
                    state_nxt = LOAD;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET_PC_ALIGNED;
        end else if (state == IDLE && pc_load) begin
            pc_q <= {pc_target[15:1], 1'b0};
        end else if (state == LOAD) begin
            pc_q <= pc_q + 16'd2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q <= 16'h0000;
        end else if (state == REQ && mem_resp) begin
            ir_q <= mem_rdata;
        end
    end

    // Memory handshake: mem_read is held high (address stable) from REQ entry until the
    // cycle that samples mem_resp=1; mem_resp in any other state is not an acknowledge.
    // Outputs decode the state register, so reset clears them without a clock edge.
    assign mem_read    = (state == REQ);
    assign mem_address = pc_q;
    assign pc_out      = pc_q;
    assign ir_load     = (state == LOAD);
    assign fetch_done  = (state == LOAD);
    assign ir_data     = ir_q;
    assign state_dbg   = state;

endmodule
